// File: rtl/fifo_pkt_reader_if.sv
// Bundle between the packet reader, its source FIFO and the downstream sink.
//   fifo_data_out : read data from the FIFO, valid the cycle after fifo_get
//   fifo_empty    : FIFO empty flag
//   fifo_get      : pop request to the FIFO
//   m_data        : word to downstream
//   m_valid       : m_data/m_sop/m_eop are valid
//   m_ready       : downstream accepts the word
//   m_sop, m_eop  : packet header / last word of packet markers
// master = the reader, slave = the environment (FIFO + sink).
interface fifo_pkt_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  fifo_empty;
  logic                  fifo_get;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_sop;
  logic                  m_eop;

  modport master (
    input  fifo_data_out, fifo_empty, m_ready,
    output fifo_get, m_data, m_valid, m_sop, m_eop
  );

  modport slave (
    output fifo_data_out, fifo_empty, m_ready,
    input  fifo_get, m_data, m_valid, m_sop, m_eop
  );
endinterface

// File: rtl/fifo_pkt_reader.sv
// Pops words from a 1-cycle-latency FIFO into a 3-entry buffer and presents
// them downstream with a valid/ready handshake, marking packet boundaries.
// A packet is a header word whose low byte gives the number of payload words
// that follow (0..255).
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fifo_pkt_reader_if.master (FIFO read side + downstream stream)
module fifo_pkt_reader #(
  parameter int DATA_WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  fifo_pkt_reader_if.master bus
);

  typedef enum logic {HDR, PAY} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [3];
  logic [1:0]            count;
  logic [1:0]            count_nx;
  logic [1:0]            wr_idx;
  logic                  inflight;
  logic                  started;
  logic                  get;
  logic                  hs;
  logic                  valid;
  logic [7:0]            remaining;

  always_comb begin
    valid    = (count != 2'd0);
    hs       = valid && bus.m_ready;
    // started masks the first cycle after reset release, before inputs have
    // been sampled at an edge.  Reads in flight count against buffer space so
    // a captured word always has a slot.
    get      = started && !bus.fifo_empty &&
               (({1'b0, count} + {2'b00, inflight}) < 3'd3);
    count_nx = count + {1'b0, inflight} - {1'b0, hs};
    // When the head leaves in the same cycle, the tail slot moves down one.
    wr_idx   = hs ? (count - 2'd1) : count;
  end

  assign bus.fifo_get = get;
  assign bus.m_valid  = valid;
  assign bus.m_data   = mem[0];
  assign bus.m_sop    = valid && (state == HDR);
  assign bus.m_eop    = valid && ((state == HDR) ? (mem[0][7:0] == 8'd0)
                                                 : (remaining == 8'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started   <= 1'b0;
      inflight  <= 1'b0;
      count     <= '0;
      remaining <= '0;
      state     <= HDR;
      for (int unsigned i = 0; i < 3; i++) mem[i] <= '0;
    end else begin
      started  <= 1'b1;
      inflight <= get;
      count    <= count_nx;

      if (hs) begin
        mem[0] <= mem[1];
        mem[1] <= mem[2];
      end
      // Later assignment overrides the shift when both hit the same slot.
      if (inflight) mem[wr_idx] <= bus.fifo_data_out;

      if (hs) begin
        case (state)
          HDR: begin
            if (mem[0][7:0] != 8'd0) begin
              remaining <= mem[0][7:0];
              state     <= PAY;
            end
          end
          PAY: begin
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) state <= HDR;
          end
          default: state <= HDR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_pkt_reader.sv
module tb_fifo_pkt_reader;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_pkt_reader_if #(.DATA_WIDTH(DW)) bus();

  fifo_pkt_reader #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // src: words still inside the FIFO; exp_q: words expected downstream, in order
  logic [DW-1:0] src[$];
  logic [DW-1:0] exp_q[$];

  int   gate_mode = 0;   // 0 none, 1 toggle empty every cycle, 2 random
  int   rdy_mode  = 1;   // 0 hold low, 1 hold high, 2 random
  logic tog = 1'b0;
  int   hs_total = 0;
  int   gets_total = 0;

  // reference model state
  int            outstanding = 0;  // words popped from FIFO not yet accepted downstream
  int            pkt_left = 0;     // payload words remaining in current packet
  logic          stall_prev = 1'b0;
  logic [DW-1:0] data_prev;
  logic          sop_prev, eop_prev;
  logic [DW-1:0] w;
  logic          esop, eeop;

  // driver snapshots (taken at negedge)
  logic          snap_get, snap_valid, snap_ready, snap_sop, snap_eop;
  logic [DW-1:0] snap_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Compare process: checks every cycle against the packet-level model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {bus.fifo_get, bus.m_valid, bus.m_sop, bus.m_eop, bus.m_data}, '0);
      outstanding = 0;
      pkt_left    = 0;
      stall_prev  = 1'b0;
    end else begin
      if (bus.fifo_get) begin
        chk("get_while_empty", bus.fifo_empty, 0);
        chk("get_over_capacity", outstanding < 3, 1);
      end
      if (stall_prev) begin
        chk("stall_valid", bus.m_valid, 1);
        chk("stall_data", bus.m_data, data_prev);
        chk("stall_flags", {bus.m_sop, bus.m_eop}, {sop_prev, eop_prev});
      end
      if (!bus.m_valid) begin
        chk("idle_flags", {bus.m_sop, bus.m_eop}, 0);
      end else if (exp_q.size() == 0) begin
        chk("unexpected_word", exp_q.size(), 1);
      end else begin
        w = exp_q[0];
        if (pkt_left == 0) begin
          esop = 1'b1;
          eeop = (w[7:0] == 8'd0);
        end else begin
          esop = 1'b0;
          eeop = (pkt_left == 1);
        end
        chk("data", bus.m_data, w);
        chk("sop", bus.m_sop, esop);
        chk("eop", bus.m_eop, eeop);
        if (bus.m_ready) begin
          void'(exp_q.pop_front());
          pkt_left = (pkt_left == 0) ? int'(w[7:0]) : pkt_left - 1;
          hs_total++;
        end
      end
      outstanding += int'(bus.fifo_get) - int'(bus.m_valid && bus.m_ready);
      gets_total  += int'(bus.fifo_get);
      stall_prev = bus.m_valid && !bus.m_ready;
      data_prev  = bus.m_data;
      sop_prev   = bus.m_sop;
      eop_prev   = bus.m_eop;
    end
  end

  // One clock of stimulus: sample at negedge, model the FIFO and sink after posedge.
  task automatic cycle();
    logic gate;
    @(negedge clk);
    snap_get   = bus.fifo_get;
    snap_valid = bus.m_valid;
    snap_ready = bus.m_ready;
    snap_sop   = bus.m_sop;
    snap_eop   = bus.m_eop;
    snap_data  = bus.m_data;
    @(posedge clk);
    #1;
    if (snap_get && rst_n && src.size() > 0) bus.fifo_data_out = src.pop_front();
    else bus.fifo_data_out = $urandom;
    tog = ~tog;
    case (gate_mode)
      1:       gate = tog;
      2:       gate = ($urandom_range(0, 3) == 0);
      default: gate = 1'b0;
    endcase
    bus.fifo_empty = (src.size() == 0) || gate;
    case (rdy_mode)
      0:       bus.m_ready = 1'b0;
      1:       bus.m_ready = 1'b1;
      default: bus.m_ready = ($urandom_range(0, 2) != 0);
    endcase
  endtask

  task automatic load_word(input logic [DW-1:0] x);
    src.push_back(x);
    exp_q.push_back(x);
  endtask

  task automatic load_pkt(input int len, output logic [DW-1:0] hdr);
    hdr = $urandom;
    hdr[7:0] = len[7:0];
    load_word(hdr);
    for (int i = 0; i < len; i++) load_word($urandom);
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      cycle();
      k++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    logic          w_get[12], w_valid[12], w_sop[12], w_eop[12];
    int            es[7] = '{1, 0, 0, 0, 1, 1, 0};
    int            ee[7] = '{0, 0, 0, 1, 1, 0, 1};
    logic [DW-1:0] hdr;
    int            n, eop_at, base, k, gbase;

    bus.fifo_data_out = '0;
    bus.fifo_empty    = 1'b1;
    bus.m_ready       = 1'b0;

    // header len 3 + 3 payloads, header-only, header len 1 + 1 payload
    load_word(32'h0000_0003);
    load_word(32'hA1A1_A101);
    load_word(32'hA2A2_A200);
    load_word(32'hA3A3_A3FF);
    load_word(32'h0000_0000);
    load_word(32'h0000_0001);
    load_word(32'hB1B1_B100);

    @(posedge clk);
    #1;
    bus.fifo_empty = 1'b0;
    bus.m_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      cycle();
      w_get[i]   = snap_get;
      w_valid[i] = snap_valid;
      w_sop[i]   = snap_sop;
      w_eop[i]   = snap_eop;
    end
    chk("first_cycle_no_get", w_get[0], 0);
    for (int i = 1; i <= 7; i++) chk("stream_get", w_get[i], 1);
    chk("get_after_source_empty", w_get[8], 0);
    chk("valid_before_latency", w_valid[2], 0);
    for (int i = 0; i < 7; i++) begin
      chk("stream_valid", w_valid[3 + i], 1);
      chk("stream_sop", w_sop[3 + i], es[i]);
      chk("stream_eop", w_eop[3 + i], ee[i]);
    end
    chk("valid_after_stream", w_valid[10], 0);

    // empty flag toggling every cycle
    gate_mode = 1;
    rdy_mode  = 1;
    for (int i = 0; i < 4; i++) load_pkt($urandom_range(0, 6), hdr);
    drain("toggle_drain", 400);

    // random gating and backpressure
    gate_mode = 2;
    rdy_mode  = 2;
    for (int i = 0; i < 12; i++) load_pkt($urandom_range(0, 9), hdr);
    drain("random_drain", 3000);

    // maximum length packet, free-flowing
    gate_mode = 0;
    rdy_mode  = 1;
    load_pkt(255, hdr);
    load_pkt(0, hdr);
    n = 0;
    eop_at = 0;
    k = 0;
    while (n < 257 && k < 400) begin
      cycle();
      k++;
      if (snap_valid && snap_ready) begin
        n++;
        if (snap_eop && eop_at == 0) eop_at = n;
      end
    end
    chk("max_len_words", n, 257);
    chk("max_len_eop_pos", eop_at, 256);
    drain("max_len_drain", 50);

    // backpressure with plenty of data in the FIFO
    rdy_mode = 0;
    load_pkt(20, hdr);
    bus.fifo_empty = 1'b0;
    bus.m_ready    = 1'b0;
    gbase = gets_total;
    repeat (10) cycle();
    chk("bp_gets", gets_total - gbase, 3);
    chk("bp_get_held_low", snap_get, 0);
    rdy_mode = 1;
    drain("bp_drain", 200);

    // reset in the middle of a packet
    load_pkt(5, hdr);
    load_pkt(2, hdr);
    bus.fifo_empty = 1'b0;
    bus.m_ready    = 1'b1;
    base = hs_total;
    k = 0;
    while (hs_total - base < 3 && k < 50) begin
      cycle();
      k++;
    end
    chk("midpkt_words_before_reset", hs_total - base, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_async", {bus.fifo_get, bus.m_valid, bus.m_sop, bus.m_eop, bus.m_data}, '0);
    src.delete();
    exp_q.delete();
    repeat (2) cycle();
    load_pkt(2, hdr);
    @(posedge clk);
    #1;
    bus.fifo_empty = 1'b0;
    rst_n = 1'b1;
    k = 0;
    snap_valid = 1'b0;
    while (!snap_valid && k < 20) begin
      cycle();
      k++;
    end
    chk("post_reset_valid", snap_valid, 1);
    chk("post_reset_sop", snap_sop, 1);
    chk("post_reset_data", snap_data, hdr);
    drain("post_reset_drain", 50);

    repeat (3) cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
